// File: rtl/qupls4_wb_arbiter.sv
// qupls4_wb_arbiter
//   Write-back arbiter in front of the multi-write-port physical register
//   file. Each of NSRC result sources owns a one-entry holding register;
//   valid entries are granted onto up to WPORTS write ports per cycle.
//   No two ports ever carry the same preg in one cycle, because the register
//   file's live-value table cannot resolve same-cycle duplicates.
//
//   Ports
//     clk                     clock, rising edge
//     rst                     asynchronous reset, active low
//     src_v / src_rdy         per-source valid / ready handshake
//     src_wa/we/i/ti          per-source preg, byte enables, value, flags
//     wr/we/wa/i/ti           registered write-port strobe and payload
//     busy                    some holding entry is valid
//
//   Build option
//     QUPLS4_WB_STARVE_EN     per-entry age counters. Entries that reach
//                             STARVE_LIM are scanned first, in index order,
//                             which bounds the wait for a repeated
//                             same-preg loser.
module qupls4_wb_arbiter #(
  parameter int NSRC       = 8,
  parameter int WPORTS     = 4,
  parameter int BWW        = 8,
  parameter int VALW       = 64,
  parameter int FLGW       = 8,
  parameter int PRGW       = 9,
  parameter int WEW        = (VALW + FLGW) / BWW + 1,
  parameter int STARVE_LIM = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NSRC-1:0]                  src_v,
  output logic [NSRC-1:0]                  src_rdy,
  input  logic [NSRC-1:0][PRGW-1:0]        src_wa,
  input  logic [NSRC-1:0][WEW-1:0]         src_we,
  input  logic [NSRC-1:0][VALW-1:0]        src_i,
  input  logic [NSRC-1:0][FLGW-1:0]        src_ti,
  output logic [WPORTS-1:0]                wr,
  output logic [WPORTS-1:0][WEW-1:0]       we,
  output logic [WPORTS-1:0][PRGW-1:0]      wa,
  output logic [WPORTS-1:0][VALW-1:0]      i,
  output logic [WPORTS-1:0][FLGW-1:0]      ti,
  output logic                             busy
);
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  if (WPORTS < 1 || WPORTS > NSRC || STARVE_LIM < 1 || STARVE_LIM > 7) begin : g_bad_param
    $error("qupls4_wb_arbiter: WPORTS must be 1..NSRC and STARVE_LIM 1..7");
  end

  logic [NSRC-1:0]                  hv_q, hv_d;
  logic [NSRC-1:0][PRGW-1:0]        hwa_q, hwa_d;
  logic [NSRC-1:0][WEW-1:0]         hwe_q, hwe_d;
  logic [NSRC-1:0][VALW-1:0]        hi_q, hi_d;
  logic [NSRC-1:0][FLGW-1:0]        hti_q, hti_d;
  logic [SW-1:0]                    rr_q, rr_d;
  logic [WPORTS-1:0]                wr_q, wr_d;
  logic [WPORTS-1:0][WEW-1:0]       we_q, we_d;
  logic [WPORTS-1:0][PRGW-1:0]      wa_q, wa_d;
  logic [WPORTS-1:0][VALW-1:0]      i_q, i_d;
  logic [WPORTS-1:0][FLGW-1:0]      ti_q, ti_d;

  logic [NSRC-1:0]                  gnt;
  logic [NSRC-1:0]                  starve;
  logic [WPORTS-1:0]                pvld;
  logic [WPORTS-1:0][SW-1:0]        psel;
  logic [SW-1:0]                    last_gnt;

`ifdef QUPLS4_WB_STARVE_EN
  logic [NSRC-1:0][2:0]             age_q, age_d;

  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      starve[s] = hv_q[s] && (age_q[s] == 3'(STARVE_LIM));
      age_d[s]  = age_q[s];
      if (src_v[s] && src_rdy[s])
        age_d[s] = '0;
      else if (hv_q[s] && !gnt[s] && age_q[s] != 3'(STARVE_LIM))
        age_d[s] = age_q[s] + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) age_q <= '0;
    else      age_q <= age_d;
  end
`else
  assign starve = '0;
`endif

  // Pass 0 picks starved entries in index order, pass 1 is the rotating
  // scan starting at rr. A grant is refused when the port budget is spent
  // or when its preg already went to an earlier port this cycle.
  always_comb begin
    int                         ngnt;
    int                         idx;
    logic                       cand;
    logic                       hit;
    logic [PRGW-1:0]            cwa;
    logic [WPORTS-1:0][PRGW-1:0] pwa;
    gnt      = '0;
    pvld     = '0;
    psel     = '0;
    pwa      = '0;
    last_gnt = rr_q;
    ngnt     = 0;
    idx      = 0;
    cand     = 1'b0;
    hit      = 1'b0;
    cwa      = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < NSRC; k++) begin
        idx  = (pass == 0) ? k : (int'(rr_q) + k) % NSRC;
        cand = 1'b0;
        cwa  = '0;
        for (int s = 0; s < NSRC; s++) begin
          if (s == idx) begin
            cand = hv_q[s] && !gnt[s] && (pass == 1 || starve[s]);
            cwa  = hwa_q[s];
          end
        end
        if (cand && ngnt < WPORTS) begin
          hit = 1'b0;
          for (int p = 0; p < WPORTS; p++)
            if (p < ngnt && pwa[p] == cwa) hit = 1'b1;
          if (!hit) begin
            for (int s = 0; s < NSRC; s++)
              if (s == idx) gnt[s] = 1'b1;
            for (int p = 0; p < WPORTS; p++) begin
              if (p == ngnt) begin
                pvld[p] = 1'b1;
                psel[p] = SW'(idx);
                pwa[p]  = cwa;
              end
            end
            last_gnt = SW'(idx);
            ngnt++;
          end
        end
      end
    end
  end

  assign src_rdy = ~hv_q | gnt;
  assign busy    = |hv_q;

  always_comb begin
    rr_d = (|gnt) ? SW'((int'(last_gnt) + 1) % NSRC) : rr_q;
    for (int p = 0; p < WPORTS; p++) begin
      wr_d[p] = pvld[p];
      we_d[p] = hwe_q[psel[p]];
      wa_d[p] = hwa_q[psel[p]];
      i_d[p]  = hi_q[psel[p]];
      ti_d[p] = hti_q[psel[p]];
    end
    for (int s = 0; s < NSRC; s++) begin
      hv_d[s]  = hv_q[s] & ~gnt[s];
      hwa_d[s] = hwa_q[s];
      hwe_d[s] = hwe_q[s];
      hi_d[s]  = hi_q[s];
      hti_d[s] = hti_q[s];
      if (src_v[s] && src_rdy[s]) begin
        // preg 0 is hard zero and an empty enable writes nothing: swallow it
        hv_d[s]  = (src_wa[s] != '0) && (src_we[s] != '0);
        hwa_d[s] = src_wa[s];
        hwe_d[s] = src_we[s];
        hi_d[s]  = src_i[s];
        hti_d[s] = src_ti[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hv_q  <= '0;
      hwa_q <= '0;
      hwe_q <= '0;
      hi_q  <= '0;
      hti_q <= '0;
      rr_q  <= '0;
      wr_q  <= '0;
      we_q  <= '0;
      wa_q  <= '0;
      i_q   <= '0;
      ti_q  <= '0;
    end else begin
      hv_q  <= hv_d;
      hwa_q <= hwa_d;
      hwe_q <= hwe_d;
      hi_q  <= hi_d;
      hti_q <= hti_d;
      rr_q  <= rr_d;
      wr_q  <= wr_d;
      we_q  <= we_d;
      wa_q  <= wa_d;
      i_q   <= i_d;
      ti_q  <= ti_d;
    end
  end

  assign wr = wr_q;
  assign we = we_q;
  assign wa = wa_q;
  assign i  = i_q;
  assign ti = ti_q;

endmodule

// File: tb/tb_qupls4_wb_arbiter.sv
// Bench for qupls4_wb_arbiter: directed scenarios plus random traffic,
// all compared against a per-source slot model kept below.
module tb_qupls4_wb_arbiter;
  localparam int NSRC   = 8;
  localparam int WPORTS = 4;
  localparam int VALW   = 64;
  localparam int FLGW   = 8;
  localparam int PRGW   = 9;
  localparam int WEW    = 10;
  localparam int LIM    = 7;

  logic                        clk;
  logic                        rst;
  logic [NSRC-1:0]             src_v;
  logic [NSRC-1:0]             src_rdy;
  logic [NSRC-1:0][PRGW-1:0]   src_wa;
  logic [NSRC-1:0][WEW-1:0]    src_we;
  logic [NSRC-1:0][VALW-1:0]   src_i;
  logic [NSRC-1:0][FLGW-1:0]   src_ti;
  logic [WPORTS-1:0]           wr;
  logic [WPORTS-1:0][WEW-1:0]  we;
  logic [WPORTS-1:0][PRGW-1:0] wa;
  logic [WPORTS-1:0][VALW-1:0] i;
  logic [WPORTS-1:0][FLGW-1:0] ti;
  logic                        busy;

  qupls4_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .src_v(src_v), .src_rdy(src_rdy), .src_wa(src_wa), .src_we(src_we),
    .src_i(src_i), .src_ti(src_ti),
    .wr(wr), .we(we), .wa(wa), .i(i), .ti(ti), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one slot per source, plus the next-scan position.
  bit               mv[NSRC];
  logic [PRGW-1:0]  mwa[NSRC];
  logic [WEW-1:0]   mwe[NSRC];
  logic [VALW-1:0]  mi[NSRC];
  logic [FLGW-1:0]  mti[NSRC];
  int               mage[NSRC];
  int               mrr;
  bit               mg[NSRC];
  int               morder[$];

  task automatic model_reset();
    for (int s = 0; s < NSRC; s++) begin
      mv[s] = 0; mage[s] = 0;
    end
    mrr = 0;
  endtask

  function automatic void try_grant(input int s);
    bit clash;
    if (!mv[s] || mg[s] || morder.size() >= WPORTS) return;
    clash = 0;
    foreach (morder[j]) if (mwa[morder[j]] == mwa[s]) clash = 1;
    if (!clash) begin
      mg[s] = 1;
      morder.push_back(s);
    end
  endfunction

  function automatic void model_grants();
    morder.delete();
    for (int s = 0; s < NSRC; s++) mg[s] = 0;
`ifdef QUPLS4_WB_STARVE_EN
    for (int s = 0; s < NSRC; s++) if (mage[s] == LIM) try_grant(s);
`endif
    for (int k = 0; k < NSRC; k++) try_grant((mrr + k) % NSRC);
  endfunction

  // One clock cycle: check combinational outputs mid-cycle, advance the
  // model, then check the registered write ports just after the edge.
  task automatic step();
    logic [NSRC-1:0]             exp_rdy;
    logic [WPORTS-1:0]           exp_wr;
    logic [PRGW-1:0]             ewa[WPORTS];
    logic [WEW-1:0]              ewe[WPORTS];
    logic [VALW-1:0]             ei[WPORTS];
    logic [FLGW-1:0]             eti[WPORTS];
    int                          n;
    bit                          any_v;
    #3;
    model_grants();
    any_v = 0;
    for (int s = 0; s < NSRC; s++) begin
      exp_rdy[s] = !mv[s] || mg[s];
      if (mv[s]) any_v = 1;
    end
    check("src_rdy", src_rdy, exp_rdy);
    check("busy", busy, any_v);
    n = morder.size();
    exp_wr = '0;
    for (int k = 0; k < n; k++) begin
      exp_wr[k] = 1'b1;
      ewa[k] = mwa[morder[k]]; ewe[k] = mwe[morder[k]];
      ei[k]  = mi[morder[k]];  eti[k] = mti[morder[k]];
    end
    if (n > 0) mrr = (morder[n-1] + 1) % NSRC;
    for (int s = 0; s < NSRC; s++) begin
      if (src_v[s] && exp_rdy[s]) begin
        mv[s]  = (src_wa[s] != 0) && (src_we[s] != 0);
        mwa[s] = src_wa[s]; mwe[s] = src_we[s];
        mi[s]  = src_i[s];  mti[s] = src_ti[s];
        mage[s] = 0;
      end else if (mg[s]) begin
        mv[s] = 0;
      end else if (mv[s] && mage[s] < LIM) begin
        mage[s]++;
      end
    end
    @(posedge clk); #1;
    check("wr", wr, exp_wr);
    for (int k = 0; k < n; k++) begin
      check($sformatf("wa[%0d]", k), wa[k], ewa[k]);
      check($sformatf("we[%0d]", k), we[k], ewe[k]);
      check($sformatf("i[%0d]", k), i[k], ei[k]);
      check($sformatf("ti[%0d]", k), ti[k], eti[k]);
    end
  endtask

  task automatic idle_inputs();
    src_v = '0; src_wa = '0; src_we = '0; src_i = '0; src_ti = '0;
  endtask

  task automatic rand_inputs();
    for (int s = 0; s < NSRC; s++) begin
      src_v[s]  = 1'($urandom_range(0, 1));
      src_wa[s] = PRGW'($urandom_range(0, 6));
      src_we[s] = ($urandom_range(0, 7) == 0) ? '0 : WEW'($urandom);
      src_i[s]  = {$urandom, $urandom};
      src_ti[s] = FLGW'($urandom);
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // quiet after reset
    for (int c = 0; c < 10; c++) begin
      step();
      check("rst_wr", wr, 4'h0);
      check("rst_rdy", src_rdy, 8'hFF);
      check("rst_busy", busy, 1'b0);
    end

    // four distinct destinations in one beat
    for (int s = 0; s < 4; s++) begin
      src_v[s] = 1'b1; src_wa[s] = PRGW'(5 + s); src_we[s] = '1;
      src_i[s] = 64'hA0 + 64'(s); src_ti[s] = FLGW'(s + 1);
    end
    step();
    idle_inputs();
    step();
    check("t2_wr", wr, 4'hF);
    check("t2_wa0", wa[0], 9'd5);
    check("t2_wa1", wa[1], 9'd6);
    check("t2_wa2", wa[2], 9'd7);
    check("t2_wa3", wa[3], 9'd8);
    check("t2_i3", i[3], 64'hA3);
    step();
    check("t2_drain", wr, 4'h0);

    // all sources streaming to distinct pregs
    for (int s = 0; s < NSRC; s++) begin
      src_v[s] = 1'b1; src_wa[s] = PRGW'(10 + s); src_we[s] = '1;
      src_ti[s] = '0;
    end
    for (int c = 0; c < 8; c++) begin
      for (int s = 0; s < NSRC; s++) src_i[s] = {32'(c), 32'(s)};
      step();
      if (c > 0) check("t3_full", wr, 4'hF);
    end

    // asynchronous reset in the middle of the stream
    #2 rst = 1'b0;
    #1;
    check("arst_wr", wr, 4'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_rdy", src_rdy, 8'hFF);
    idle_inputs();
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // two sources racing for preg 9
    src_v[1] = 1'b1; src_wa[1] = 9'd9; src_we[1] = '1; src_i[1] = 64'h1111;
    src_v[2] = 1'b1; src_wa[2] = 9'd9; src_we[2] = '1; src_i[2] = 64'h2222;
    step();
    idle_inputs();
    step();
    check("t4_wr1", wr, 4'h1);
    check("t4_wa1", wa[0], 9'd9);
    check("t4_i1", i[0], 64'h1111);
    step();
    check("t4_wr2", wr, 4'h1);
    check("t4_wa2", wa[0], 9'd9);
    check("t4_i2", i[0], 64'h2222);

    // beats to preg 0 or with no enables are swallowed
    for (int s = 0; s < NSRC; s++) begin
      src_v[s]  = 1'b1;
      src_wa[s] = (s % 2 == 0) ? '0 : PRGW'(20 + s);
      src_we[s] = (s % 2 == 0) ? '1 : '0;
      src_i[s]  = 64'hDEAD;
    end
    step();
    check("t5_busy", busy, 1'b0);
    idle_inputs();
    step();
    check("t5_wr", wr, 4'h0);

    // random traffic with frequent preg collisions and drops
    for (int c = 0; c < 2000; c++) begin
      rand_inputs();
      step();
    end
    idle_inputs();
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
